// File: rtl/io_pkg.sv
// Shared definitions for pin-level I/O blocks.
// Contents:
//   hs_state_t - state of a 4-phase req/ack handshake receiver.
package io_pkg;

  typedef enum logic [0:0] {
    WAIT_REQ = 1'b0,  // idle, waiting for the host to raise req
    WAIT_REL = 1'b1   // ack raised, waiting for the host to drop req
  } hs_state_t;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single asynchronous pin input.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, flushes the chain to 0
//   d   - asynchronous input
//   q   - synchronized output, DEPTH cycles of latency
module synchronizer #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain_r;

  // Shift chain; bit 0 is the metastability-exposed flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[DEPTH-2:0], d};
    end
  end

  assign q = chain_r[DEPTH-1];

endmodule

// File: rtl/high_speed_in_port.sv
// Host-facing input port: receives beats over an asynchronous 4-phase
// req/ack bus, assembles them LSB-first into WIDTH-bit chunks and hands
// each chunk to the input memory through a single-entry holding slot.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   enable          - input memory enabled; gates delivery of the slot
//   in_idle         - core idle; flushes partial chunk and holding slot
//   data_required   - input memory still wants blocks
//   host_ready      - data_required & enable, advisory to the host
//   ext_req         - asynchronous host request
//   ext_data        - beat data, stable while ext_req is high
//   ext_ack         - registered acknowledge to the host
//   data_available  - chunk strobe (slot occupied & enable)
//   data_out        - chunk held in the slot
//   stalled         - a last beat is being withheld for lack of slot space
module high_speed_in_port
  import io_pkg::*;
#(
  parameter int IN_BUS_WIDTH = 4,
  parameter int WIDTH        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    in_idle,
  input  logic                    data_required,
  output logic                    host_ready,
  input  logic                    ext_req,
  input  logic [IN_BUS_WIDTH-1:0] ext_data,
  output logic                    ext_ack,
  output logic                    data_available,
  output logic [WIDTH-1:0]        data_out,
  output logic                    stalled
);

  localparam int BEATS            = WIDTH / IN_BUS_WIDTH;
  localparam int BeatCounterWidth = ($clog2(BEATS) > 1) ? $clog2(BEATS) : 1;
  localparam logic [BeatCounterWidth-1:0] LastBeat = BeatCounterWidth'(BEATS - 1);

  if ((WIDTH % IN_BUS_WIDTH) != 0) begin : g_width_check
    $fatal(1, "high_speed_in_port: WIDTH must be a multiple of IN_BUS_WIDTH");
  end

  logic                        req_sync_s;
  hs_state_t                   state_r;
  hs_state_t                   state_nx_s;
  logic                        ack_r;
  logic                        ack_nx_s;
  logic [BeatCounterWidth-1:0] beat_r;
  logic [WIDTH-1:0]            shift_r;
  logic [WIDTH-1:0]            data_out_r;
  logic                        pending_r;
  logic                        last_beat_s;
  logic                        accept_s;
  logic                        capture_s;
  logic                        data_available_s;
  logic [WIDTH-1:0]            chunk_s;

  synchronizer #(.DEPTH(2)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_req),
    .q   (req_sync_s)
  );

  assign data_available_s = pending_r & enable;
  assign last_beat_s      = (beat_r == LastBeat);
  // A last beat may only land if the slot is empty or being drained now.
  assign accept_s         = !(last_beat_s & pending_r & !data_available_s);
  assign capture_s        = (state_r == WAIT_REQ) & req_sync_s & accept_s;

  // Completed chunk: the last beat fills the top slice, earlier beats come from shift_r.
  always_comb begin
    chunk_s = shift_r;
    chunk_s[WIDTH-1 -: IN_BUS_WIDTH] = ext_data;
  end

  // Handshake next-state and acknowledge.
  always_comb begin
    state_nx_s = state_r;
    ack_nx_s   = ack_r;
    case (state_r)
      WAIT_REQ: begin
        if (capture_s) begin
          state_nx_s = WAIT_REL;
          ack_nx_s   = 1'b1;
        end else begin
          state_nx_s = WAIT_REQ;
          ack_nx_s   = 1'b0;
        end
      end
      WAIT_REL: begin
        if (!req_sync_s) begin
          state_nx_s = WAIT_REQ;
          ack_nx_s   = 1'b0;
        end else begin
          state_nx_s = WAIT_REL;
          ack_nx_s   = 1'b1;
        end
      end
      default: begin
        state_nx_s = WAIT_REQ;
        ack_nx_s   = 1'b0;
      end
    endcase
  end

  // Handshake state and acknowledge registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= WAIT_REQ;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ack_r   <= ack_nx_s;
    end
  end

  // Beat counter, shift register and holding slot. in_idle discards any
  // capture on the same edge while the handshake itself carries on.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_r     <= '0;
      shift_r    <= '0;
      data_out_r <= '0;
      pending_r  <= 1'b0;
    end else if (in_idle) begin
      beat_r    <= '0;
      shift_r   <= '0;
      pending_r <= 1'b0;
    end else begin
      if (data_available_s) begin
        pending_r <= 1'b0;
      end
      if (capture_s) begin
        if (last_beat_s) begin
          // A refill on the drain edge keeps pending set.
          data_out_r <= chunk_s;
          pending_r  <= 1'b1;
          beat_r     <= '0;
        end else begin
          shift_r[int'(beat_r)*IN_BUS_WIDTH +: IN_BUS_WIDTH] <= ext_data;
          beat_r <= beat_r + BeatCounterWidth'(1);
        end
      end
    end
  end

  assign host_ready     = data_required & enable;
  assign ext_ack        = ack_r;
  assign data_available = data_available_s;
  assign data_out       = data_out_r;
  assign stalled        = (state_r == WAIT_REQ) & req_sync_s & !accept_s;

endmodule
